// File: rtl/tile_sequencer.sv
// tile_sequencer: walks PE-array-sized output tiles of an MxK * KxN product, issuing operand
// reads, PE masks and output writes per tile. Perf counters are built only with TILE_SEQ_PERF_CNT_EN.
module tile_sequencer #(
    parameter int ROWS      = 32,
    parameter int ROWS_LOG2 = 5,
    parameter int COLS      = 32,
    parameter int COLS_LOG2 = 5,
    parameter int DIM_W     = 9,
    parameter int OPND1_AW  = 10,
    parameter int OPND2_AW  = 10,
    parameter int OUT_AW    = 10
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic                STALL,
    input  logic                TILE_ORDER_in,
    input  logic [DIM_W-1:0]    M_SIZE_in,
    input  logic [DIM_W-1:0]    K_SIZE_in,
    input  logic [DIM_W-1:0]    N_SIZE_in,
    output logic [OPND1_AW-1:0] OPND1_SRAM_ADDR_out,
    output logic                OPND1_SRAM_REN_out,
    output logic [OPND2_AW-1:0] OPND2_SRAM_ADDR_out,
    output logic                OPND2_SRAM_REN_out,
    output logic [OUT_AW-1:0]   OUT_SRAM_ADDR_out,
    output logic                OUT_SRAM_WEN_out,
    output logic [ROWS-1:0]     PE_ROW_VALID_out,
    output logic [COLS-1:0]     PE_COL_VALID_out,
    output logic                IS_COMPUTING_out,
    output logic                IS_FLUSHING_out,
    output logic                BUSY_out,
    output logic                DONE_out,
    output logic                ERR_out
`ifdef TILE_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]         PERF_BUSY_CYCLES_out,
    output logic [31:0]         PERF_STALL_CYCLES_out
`endif
);

    localparam int CW = DIM_W + 2;
    localparam int PW = 2 * CW + 4;

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_FLUSH, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_m, r_k, r_n;
    logic            r_order;
    logic            r_err;
    logic [CW-1:0]   r_tr, r_tc, r_c, r_r;

    logic [CW-1:0]   w_ntr, w_ntc, w_rem_r, w_rem_c, w_ar, w_ac, w_c_hold;
    logic            w_start_ok, w_zero_req, w_busy_st;
    logic            w_c_last, w_r_last, w_last_tile;

    assign w_start_ok  = (r_state == S_IDLE) && START;
    assign w_zero_req  = (M_SIZE_in == '0) || (K_SIZE_in == '0) || (N_SIZE_in == '0);
    assign w_busy_st   = (r_state == S_COMPUTE) || (r_state == S_FLUSH);

    assign w_ntr       = (r_m + CW'(ROWS - 1)) >> ROWS_LOG2;
    assign w_ntc       = (r_n + CW'(COLS - 1)) >> COLS_LOG2;
    assign w_rem_r     = r_m - (r_tr << ROWS_LOG2);
    assign w_rem_c     = r_n - (r_tc << COLS_LOG2);
    assign w_ar        = (w_rem_r >= CW'(ROWS)) ? CW'(ROWS) : w_rem_r;
    assign w_ac        = (w_rem_c >= CW'(COLS)) ? CW'(COLS) : w_rem_c;

    assign w_c_last    = (r_c + CW'(3)) == (r_k + w_ar + w_ac);
    assign w_r_last    = r_r == (w_ar - CW'(1));
    assign w_last_tile = (r_tr == w_ntr - CW'(1)) && (r_tc == w_ntc - CW'(1));
    // c is only cleared when the next tile starts, so the operand addresses keep holding through FLUSH
    assign w_c_hold    = (r_c < r_k) ? r_c : (r_k - CW'(1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (START) w_state_nxt = w_zero_req ? S_DONE : S_COMPUTE;
            S_COMPUTE: if (!STALL && w_c_last) w_state_nxt = S_FLUSH;
            S_FLUSH:   if (!STALL && w_r_last) w_state_nxt = w_last_tile ? S_DONE : S_COMPUTE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_m     <= '0;
            r_k     <= '0;
            r_n     <= '0;
            r_order <= 1'b0;
            r_err   <= 1'b0;
            r_tr    <= '0;
            r_tc    <= '0;
            r_c     <= '0;
            r_r     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_m     <= CW'(M_SIZE_in);
                r_k     <= CW'(K_SIZE_in);
                r_n     <= CW'(N_SIZE_in);
                r_order <= TILE_ORDER_in;
                r_err   <= w_zero_req;
                r_tr    <= '0;
                r_tc    <= '0;
                r_c     <= '0;
                r_r     <= '0;
            end
            if (r_state == S_COMPUTE && !STALL && !w_c_last) begin
                r_c <= r_c + CW'(1);
            end
            if (r_state == S_FLUSH && !STALL) begin
                if (!w_r_last) begin
                    r_r <= r_r + CW'(1);
                end else begin
                    r_r <= '0;
                    r_c <= '0;
                    if (!w_last_tile) begin
                        if (!r_order) begin
                            if (r_tc == w_ntc - CW'(1)) begin
                                r_tc <= '0;
                                r_tr <= r_tr + CW'(1);
                            end else begin
                                r_tc <= r_tc + CW'(1);
                            end
                        end else begin
                            if (r_tr == w_ntr - CW'(1)) begin
                                r_tr <= '0;
                                r_tc <= r_tc + CW'(1);
                            end else begin
                                r_tr <= r_tr + CW'(1);
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        OPND1_SRAM_ADDR_out = '0;
        OPND2_SRAM_ADDR_out = '0;
        OUT_SRAM_ADDR_out   = '0;
        PE_ROW_VALID_out    = '0;
        PE_COL_VALID_out    = '0;
        if (w_busy_st) begin
            OPND1_SRAM_ADDR_out = OPND1_AW'(PW'(w_c_hold) * PW'(w_ntr) + PW'(r_tr));
            OPND2_SRAM_ADDR_out = OPND2_AW'(PW'(w_c_hold) * PW'(w_ntc) + PW'(r_tc));
            OUT_SRAM_ADDR_out   = OUT_AW'(((PW'(r_tr) << ROWS_LOG2) + PW'(r_r)) * PW'(w_ntc)
                                          + PW'(r_tc));
            for (int unsigned i = 0; i < ROWS; i++) PE_ROW_VALID_out[i] = CW'(i) < w_ar;
            for (int unsigned j = 0; j < COLS; j++) PE_COL_VALID_out[j] = CW'(j) < w_ac;
        end
        // a stalled cycle drops the strobes; the held operation repeats once STALL falls
        OPND1_SRAM_REN_out = (r_state == S_COMPUTE) && (r_c < r_k) && !STALL;
        OPND2_SRAM_REN_out = (r_state == S_COMPUTE) && (r_c < r_k) && !STALL;
        OUT_SRAM_WEN_out   = (r_state == S_FLUSH) && !STALL;
        IS_COMPUTING_out   = r_state == S_COMPUTE;
        IS_FLUSHING_out    = r_state == S_FLUSH;
        BUSY_out           = r_state != S_IDLE;
        DONE_out           = r_state == S_DONE;
        ERR_out            = (r_state == S_DONE) && r_err;
    end

`ifdef TILE_SEQ_PERF_CNT_EN
    logic [31:0] r_perf_busy, r_perf_stall;

    always_ff @(posedge CLK) begin
        if (RST || w_start_ok) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else if (w_busy_st) begin
            if (r_perf_busy != '1) r_perf_busy <= r_perf_busy + 32'd1;
            if (STALL && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign PERF_BUSY_CYCLES_out  = r_perf_busy;
    assign PERF_STALL_CYCLES_out = r_perf_stall;
`endif

endmodule

// File: tb/tb_tile_sequencer.sv
// tb_tile_sequencer: directed and random jobs on a 4x4 array, checked cycle by cycle against
// a tile-list model built from the tile geometry rules.
module tb_tile_sequencer;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DIM_W = 9;
    localparam int AW    = 10;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              START = 1'b0;
    logic              STALL = 1'b0;
    logic              TILE_ORDER_in = 1'b0;
    logic [DIM_W-1:0]  M_SIZE_in = '0;
    logic [DIM_W-1:0]  K_SIZE_in = '0;
    logic [DIM_W-1:0]  N_SIZE_in = '0;
    logic [AW-1:0]     OPND1_SRAM_ADDR_out, OPND2_SRAM_ADDR_out, OUT_SRAM_ADDR_out;
    logic              OPND1_SRAM_REN_out, OPND2_SRAM_REN_out, OUT_SRAM_WEN_out;
    logic [ROWS-1:0]   PE_ROW_VALID_out;
    logic [COLS-1:0]   PE_COL_VALID_out;
    logic              IS_COMPUTING_out, IS_FLUSHING_out, BUSY_out, DONE_out, ERR_out;
`ifdef TILE_SEQ_PERF_CNT_EN
    logic [31:0]       PERF_BUSY_CYCLES_out, PERF_STALL_CYCLES_out;
`endif

    tile_sequencer #(
        .ROWS(ROWS), .ROWS_LOG2(2), .COLS(COLS), .COLS_LOG2(2), .DIM_W(DIM_W),
        .OPND1_AW(AW), .OPND2_AW(AW), .OUT_AW(AW)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .STALL(STALL), .TILE_ORDER_in(TILE_ORDER_in),
        .M_SIZE_in(M_SIZE_in), .K_SIZE_in(K_SIZE_in), .N_SIZE_in(N_SIZE_in),
        .OPND1_SRAM_ADDR_out(OPND1_SRAM_ADDR_out), .OPND1_SRAM_REN_out(OPND1_SRAM_REN_out),
        .OPND2_SRAM_ADDR_out(OPND2_SRAM_ADDR_out), .OPND2_SRAM_REN_out(OPND2_SRAM_REN_out),
        .OUT_SRAM_ADDR_out(OUT_SRAM_ADDR_out), .OUT_SRAM_WEN_out(OUT_SRAM_WEN_out),
        .PE_ROW_VALID_out(PE_ROW_VALID_out), .PE_COL_VALID_out(PE_COL_VALID_out),
        .IS_COMPUTING_out(IS_COMPUTING_out), .IS_FLUSHING_out(IS_FLUSHING_out),
        .BUSY_out(BUSY_out), .DONE_out(DONE_out), .ERR_out(ERR_out)
`ifdef TILE_SEQ_PERF_CNT_EN
        , .PERF_BUSY_CYCLES_out(PERF_BUSY_CYCLES_out),
        .PERF_STALL_CYCLES_out(PERF_STALL_CYCLES_out)
`endif
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];
    logic [63:0] care_q[$];
    int          kind_q[$];       // 0 compute, 1 flush, 2 done
    int          rd1_q[$];
    int          wr_q[$];
    int          en_cnt, lat, stalls, n_busy_rec;
    logic [63:0] ALL, ADDR_OUT, ADDR_OP, EN_BITS;

    function automatic logic [63:0] mk(input logic busy, comp, fl, dn, er,
                                       input logic [3:0] rm, cm,
                                       input logic r1, input logic [9:0] a1,
                                       input logic r2, input logic [9:0] a2,
                                       input logic w, input logic [9:0] oa);
        return {18'b0, busy, comp, fl, dn, er, rm, cm, r1, a1, r2, a2, w, oa};
    endfunction

    function automatic logic [63:0] obs();
        return mk(BUSY_out, IS_COMPUTING_out, IS_FLUSHING_out, DONE_out, ERR_out,
                  PE_ROW_VALID_out, PE_COL_VALID_out, OPND1_SRAM_REN_out, OPND1_SRAM_ADDR_out,
                  OPND2_SRAM_REN_out, OPND2_SRAM_ADDR_out, OUT_SRAM_WEN_out, OUT_SRAM_ADDR_out);
    endfunction

    function automatic int qget(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic push(input logic [63:0] e, input logic [63:0] c, input int k);
        exp_q.push_back(e);
        care_q.push_back(c);
        kind_q.push_back(k);
        if (k != 2) n_busy_rec++;
    endtask

    // Expected unstalled cycle list: every tile in visiting order, then the DONE cycle
    task automatic build_model(input int m, input int k, input int n, input int order);
        exp_q.delete(); care_q.delete(); kind_q.delete();
        n_busy_rec = 0;
        if (m == 0 || k == 0 || n == 0) begin
            push(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), ALL & ~ADDR_OUT & ~ADDR_OP, 2);
            return;
        end
        begin
            int trn = (m + ROWS - 1) / ROWS;
            int tcn = (n + COLS - 1) / COLS;
            for (int o = 0; o < trn * tcn; o++) begin
                int tr, tc, ar, ac;
                logic [3:0] rm, cm;
                if (order == 0) begin tr = o / tcn; tc = o % tcn; end
                else            begin tr = o % trn; tc = o / trn; end
                ar = (m - tr * ROWS > ROWS) ? ROWS : m - tr * ROWS;
                ac = (n - tc * COLS > COLS) ? COLS : n - tc * COLS;
                rm = 4'((1 << ar) - 1);
                cm = 4'((1 << ac) - 1);
                for (int c = 0; c < k + ar + ac - 2; c++) begin
                    int cc = (c < k) ? c : k - 1;
                    push(mk(1, 1, 0, 0, 0, rm, cm, c < k, 10'((cc * trn + tr) % 1024),
                            c < k, 10'((cc * tcn + tc) % 1024), 0, 0), ALL & ~ADDR_OUT, 0);
                end
                for (int r = 0; r < ar; r++) begin
                    push(mk(1, 0, 1, 0, 0, rm, cm, 0, 0, 0, 0, 1,
                            10'(((tr * ROWS + r) * tcn + tc) % 1024)), ALL & ~ADDR_OP, 1);
                end
            end
            push(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), ALL & ~ADDR_OUT & ~ADDR_OP, 2);
        end
    endtask

    // smode: 0 no stall, 1 random stall, 2 nst stalled cycles while c=1 of the first tile
    task automatic run_job(input int m, input int k, input int n, input int order,
                           input int smode, input int nst, input bit abort);
        int  cyc = 0;
        int  idx = 0;
        bit  aborted = 0;
        build_model(m, k, n, order);
        rd1_q.delete(); wr_q.delete();
        en_cnt = 0; lat = -1; stalls = 0;
        @(posedge CLK); #1;
        START = 1'b1; STALL = 1'b0; RST = 1'b0;
        M_SIZE_in = DIM_W'(m); K_SIZE_in = DIM_W'(k); N_SIZE_in = DIM_W'(n);
        TILE_ORDER_in = order[0];
        @(posedge CLK); #1;
        while (exp_q.size() > 0 && cyc < 3000) begin
            logic st;
            st = 1'b0;
            if (kind_q[0] != 2) begin
                if (smode == 1)      st = ($urandom % 4) == 0;
                else if (smode == 2) st = (idx == 1) && (stalls < nst);
            end
            if (st) stalls++;
            STALL = (kind_q[0] == 2) ? 1'($urandom % 2) : st;
            START = 1'($urandom % 2);
            M_SIZE_in = DIM_W'($urandom); K_SIZE_in = DIM_W'($urandom);
            N_SIZE_in = DIM_W'($urandom); TILE_ORDER_in = 1'($urandom % 2);
            if (abort && kind_q[0] == 1) begin RST = 1'b1; aborted = 1; end
            #1;
            chk("trace", obs() & care_q[0], (exp_q[0] & ~(st ? EN_BITS : 64'd0)) & care_q[0]);
            if (OPND1_SRAM_REN_out) begin rd1_q.push_back(int'(OPND1_SRAM_ADDR_out)); en_cnt++; end
            if (OPND2_SRAM_REN_out) en_cnt++;
            if (OUT_SRAM_WEN_out) begin wr_q.push_back(int'(OUT_SRAM_ADDR_out)); en_cnt++; end
            if (kind_q[0] == 2) lat = cyc;
            if (aborted) break;
            if (!st) begin
                void'(exp_q.pop_front()); void'(care_q.pop_front()); void'(kind_q.pop_front());
                idx++;
            end
            cyc++;
            @(posedge CLK); #1;
        end
        if (aborted) begin
            @(posedge CLK); #1;
            START = 1'b0; STALL = 1'($urandom % 2);
            #1 chk("abort_reset_outputs", obs(), 64'd0);
            RST = 1'b0;
            @(posedge CLK); #2;
            chk("abort_idle", obs() & ALL & ~ADDR_OUT & ~ADDR_OP, 64'd0);
            chk("abort_no_done", lat, -1);
        end else begin
            if (exp_q.size() != 0) chk("cycle_budget", exp_q.size(), 0);
            START = 1'b0; STALL = 1'b0;
            #1 chk("idle_after_done", obs() & ALL & ~ADDR_OUT & ~ADDR_OP, 64'd0);
`ifdef TILE_SEQ_PERF_CNT_EN
            chk("perf_busy", PERF_BUSY_CYCLES_out, n_busy_rec + stalls);
            chk("perf_stall", PERF_STALL_CYCLES_out, stalls);
`endif
        end
    endtask

    initial begin
        ALL      = mk(1, 1, 1, 1, 1, 4'hf, 4'hf, 1, 10'h3ff, 1, 10'h3ff, 1, 10'h3ff);
        ADDR_OUT = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h3ff);
        ADDR_OP  = mk(0, 0, 0, 0, 0, 0, 0, 0, 10'h3ff, 0, 10'h3ff, 0, 0);
        EN_BITS  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0);

        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1 chk("reset_outputs", obs(), 64'd0);
        RST = 1'b0;

        run_job(6, 3, 5, 0, 0, 0, 0);
        chk("done_latency_order0", lat, 38);
        chk("tile11_out_addrs", {32'(qget(wr_q, wr_q.size() - 2)), 32'(qget(wr_q, wr_q.size() - 1))},
            {32'd9, 32'd11});

        run_job(6, 3, 5, 1, 0, 0, 0);
        chk("tile10_opnd1_addrs", {16'(qget(rd1_q, 3)), 16'(qget(rd1_q, 4)), 16'(qget(rd1_q, 5))},
            {16'd1, 16'd3, 16'd5});
        chk("done_latency_order1", lat, 38);

        run_job(4, 1, 4, 0, 0, 0, 0);
        chk("single_read_count", rd1_q.size(), 1);
        chk("single_read_addr", qget(rd1_q, 0), 0);
        chk("out_addrs_4x4", {16'(qget(wr_q, 0)), 16'(qget(wr_q, 1)), 16'(qget(wr_q, 2)),
                              16'(qget(wr_q, 3))}, {16'd0, 16'd1, 16'd2, 16'd3});
        chk("latency_4x1x4", lat, 11);

        run_job(5, 0, 3, 0, 1, 0, 0);
        chk("zero_size_latency", lat, 0);
        chk("zero_size_enables", en_cnt, 0);

        run_job(6, 3, 5, 0, 2, 3, 0);
        chk("stall3_latency", lat, 41);
        run_job(6, 3, 5, 0, 2, 3, 1);
        run_job(6, 3, 5, 0, 0, 0, 0);
        chk("restart_latency", lat, 38);

`ifdef TILE_SEQ_PERF_CNT_EN
        run_job(6, 3, 5, 0, 2, 5, 0);
        chk("perf_busy_43", PERF_BUSY_CYCLES_out, 43);
        chk("perf_stall_5", PERF_STALL_CYCLES_out, 5);
`endif

        for (int j = 0; j < 14; j++) begin
            int m = $urandom_range(1, 11);
            int k = $urandom_range(1, 7);
            int n = $urandom_range(1, 11);
            if ($urandom % 10 == 0) m = 0;
            if ($urandom % 10 == 0) n = 0;
            run_job(m, k, n, $urandom_range(0, 1), 1, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
